// File: rtl/fpna_pkg.sv
// Shared definitions for the FPNA configuration loader: defaults, CRC polynomial,
// loader state encoding and a single-step CRC-8 helper.
package fpna_pkg;

    localparam int         BS_BITS_DEFAULT = 259;
    localparam logic [7:0] CRC8_POLY       = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    // One bit of an MSB-first CRC-8 shift: feedback is the top bit xor the incoming bit.
    function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic bitIn);
        crc8Step = {crc[6:0], 1'b0} ^ ((crc[7] ^ bitIn) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/fpna_crc8_serial.sv
// Bit-serial CRC-8 accumulator (init 0x00). 'clear' has priority over 'bit_en'.
module fpna_crc8_serial
    import fpna_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: restart on clear, otherwise absorb one bit when enabled.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (bit_en) begin
            crc_d = crc8Step(crc_q, bit_in);
        end
    end

    // CRC register; reset is expressed by the owner through 'clear'.
    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/fpna_config_loader.sv
// Streams configuration bytes MSB-first into the fabric chain and, on verify
// passes, checks the bits returned from the far end of the chain against a
// CRC-8 signature of the previous pass.
module fpna_config_loader
    import fpna_pkg::*;
#(
    parameter int BS_BITS = BS_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       verify,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       cfg_en,
    output logic       cfg_bs,
    input  logic       cfg_bs_ret,
    output logic       busy,
    output logic       done,
    output logic       readback_err,
    output logic [8:0] bit_count
);

    localparam logic [8:0] BS_LAST   = 9'(BS_BITS);
    localparam logic [8:0] BS_PENULT = 9'(BS_BITS - 1);

    loader_state_e state_q, state_d;
    logic [8:0]    bitCount_q, bitCount_d;
    logic [7:0]    shiftData_q, shiftData_d;
    logic [3:0]    shiftCnt_q, shiftCnt_d;
    logic          cfgEn_q, cfgEn_d;
    logic          cfgBs_q, cfgBs_d;
    logic          verify_q, verify_d;
    logic          readbackErr_q, readbackErr_d;
    logic [7:0]    crcRef_q, crcRef_d;

    logic          startAccept;
    logic          byteReady;
    logic          crcClear;
    logic [7:0]    crcRun;
    logic [7:0]    crcSent;

    // Next-state, shifter and handshake logic; a byte may be taken while the last
    // bit of the previous one is shifting so a steady stream has no bubbles, and
    // no byte is taken that could not contribute at least one bit.
    always_comb begin
        state_d       = state_q;
        bitCount_d    = bitCount_q;
        shiftData_d   = shiftData_q;
        shiftCnt_d    = shiftCnt_q;
        cfgEn_d       = 1'b0;
        cfgBs_d       = cfgBs_q;
        verify_d      = verify_q;
        readbackErr_d = readbackErr_q;
        crcRef_d      = crcRef_q;
        startAccept   = 1'b0;
        byteReady     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    bitCount_d  = 9'd0;
                    shiftData_d = 8'h00;
                    shiftCnt_d  = 4'd0;
                    verify_d    = verify;
                    startAccept = 1'b1;
                end
            end
            ST_LOAD: begin
                byteReady = (bitCount_q < BS_LAST) &&
                            ((shiftCnt_q == 4'd0) ||
                             ((shiftCnt_q == 4'd1) && (bitCount_q < BS_PENULT)));
                if ((shiftCnt_q != 4'd0) && (bitCount_q < BS_LAST)) begin
                    cfgEn_d     = 1'b1;
                    cfgBs_d     = shiftData_q[7];
                    shiftData_d = {shiftData_q[6:0], 1'b0};
                    shiftCnt_d  = shiftCnt_q - 4'd1;
                    bitCount_d  = bitCount_q + 9'd1;
                end
                if (byteReady && byte_valid) begin
                    shiftData_d = byte_data;
                    shiftCnt_d  = 4'd8;
                end
                if (bitCount_q == BS_LAST) begin
                    state_d     = ST_DONE;
                    shiftData_d = 8'h00;
                    shiftCnt_d  = 4'd0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (verify_q) begin
                    readbackErr_d = (crcRun != crcRef_q);
                    crcRef_d      = crcSent;
                end else begin
                    crcRef_d      = crcRun;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bitCount_q    <= 9'd0;
            shiftData_q   <= 8'h00;
            shiftCnt_q    <= 4'd0;
            cfgEn_q       <= 1'b0;
            cfgBs_q       <= 1'b0;
            verify_q      <= 1'b0;
            readbackErr_q <= 1'b0;
            crcRef_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            bitCount_q    <= bitCount_d;
            shiftData_q   <= shiftData_d;
            shiftCnt_q    <= shiftCnt_d;
            cfgEn_q       <= cfgEn_d;
            cfgBs_q       <= cfgBs_d;
            verify_q      <= verify_d;
            readbackErr_q <= readbackErr_d;
            crcRef_q      <= crcRef_d;
        end
    end

    assign crcClear = !rst_n || startAccept;

    // Running signature: the bits actually returned on verify, the bits driven on load.
    fpna_crc8_serial u_crc_run (
        .clk    (clk),
        .clear  (crcClear),
        .bit_en (cfgEn_q),
        .bit_in (verify_q ? cfg_bs_ret : cfgBs_q),
        .crc    (crcRun)
    );

    // Signature of the bits driven this pass; becomes the reference after a verify.
    fpna_crc8_serial u_crc_sent (
        .clk    (clk),
        .clear  (crcClear),
        .bit_en (cfgEn_q),
        .bit_in (cfgBs_q),
        .crc    (crcSent)
    );

    assign byte_ready   = byteReady;
    assign cfg_en       = cfgEn_q;
    assign cfg_bs       = cfgBs_q;
    assign busy         = (state_q == ST_LOAD);
    assign done         = (state_q == ST_DONE);
    assign readback_err = readbackErr_q;
    assign bit_count    = bitCount_q;

endmodule

// File: tb/tb_fpna_config_loader.sv
// Scoreboard bench for fpna_config_loader with a behavioural model of the fabric chain.
module tb_fpna_config_loader;

    localparam int BS     = 259;
    localparam int NBYTES = 33;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start      = 1'b0;
    logic       verify     = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       cfg_en;
    logic       cfg_bs;
    logic       cfg_bs_ret;
    logic       busy;
    logic       done;
    logic       readback_err;
    logic [8:0] bit_count;

    always #5 clk = ~clk;

    fpna_config_loader #(.BS_BITS(BS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .verify       (verify),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .cfg_en       (cfg_en),
        .cfg_bs       (cfg_bs),
        .cfg_bs_ret   (cfg_bs_ret),
        .busy         (busy),
        .done         (done),
        .readback_err (readback_err),
        .bit_count    (bit_count)
    );

    // Fabric chain: a BS-bit shift register clocked by config_en, bs_out at the far end.
    logic [BS-1:0] chain    = '0;
    logic [BS-1:0] flipMask = '0;
    logic          flipReq  = 1'b0;
    assign cfg_bs_ret = chain[BS-1];

    always @(posedge clk) begin
        if (flipReq)     chain <= chain ^ flipMask;
        else if (cfg_en) chain <= {chain[BS-2:0], cfg_bs};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BS-1:0] chain;
        int            idle;
        int            run;
        logic          err;
    } exp_t;

    exp_t          expQ[$];
    int            checks = 0;
    int            fails  = 0;
    logic [BS-1:0] modelChain = '0;
    logic [7:0]    modelRef   = 8'h00;
    logic          modelErr   = 1'b0;

    // CRC-8 (x^8+x^2+x+1, init 0) over a bit stream, oldest bit in the MSB.
    function automatic logic [7:0] crcOf(input logic [BS-1:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = BS - 1; i >= 0; i--) begin
            fb = c[7] ^ v[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: tracks cfg_en activity per pass and checks each done against the scoreboard.
    int enCnt = 0, idleCnt = 0, runCur = 0, runMax = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done with empty scoreboard, expected no done");
            end else begin
                e = expQ.pop_front();
                checkOutput("done_bit_count", BS'(bit_count), BS'(BS));
                checkOutput("chain_content", chain, e.chain);
                checkOutput("cfg_en_cycles", BS'(enCnt), BS'(BS));
                if (e.idle >= 0) checkOutput("cfg_en_bubbles", BS'(idleCnt), BS'(e.idle));
                if (e.run > 0)   checkOutput("cfg_en_run", BS'(runMax), BS'(e.run));
                @(negedge clk);
                checkOutput("readback_err", BS'(readback_err), BS'(e.err));
                checkOutput("busy_after_done", BS'(busy), BS'(0));
                checkOutput("done_one_cycle", BS'(done), BS'(0));
            end
            enCnt = 0; idleCnt = 0; runCur = 0; runMax = 0;
        end else if (!busy) begin
            enCnt = 0; idleCnt = 0; runCur = 0; runMax = 0;
        end else if (cfg_en) begin
            enCnt++;
            runCur++;
            if (runCur > runMax) runMax = runCur;
        end else begin
            idleCnt++;
            runCur = 0;
        end
    end

    // One pass. mode 0: valid always high, 1: 5 refused offers after every 4th byte,
    // 2: random valid. pat<0 gives random bytes. abortAt>0 resets at that bit count.
    task automatic applyStimulus(input bit vfy, input int mode, input int pat, input int abortAt, input bit poke);
        logic [7:0]    bytes [40];
        logic [BS-1:0] sent;
        exp_t          e;
        int            idx, gapLeft, firstEn, startAt, budget;
        bit            doneSeen, aborted;

        for (int i = 0; i < 40; i++) bytes[i] = (pat < 0) ? 8'($urandom) : 8'(pat);
        for (int i = 0; i < BS; i++) sent[BS-1-i] = bytes[i/8][7-(i%8)];

        if (abortAt == 0) begin
            e.chain = sent;
            e.idle  = (mode == 0) ? 2 : (mode == 1) ? 2 + 5 * ((NBYTES - 1) / 4) : -1;
            e.run   = (mode == 0) ? BS : 0;
            if (vfy) modelErr = (crcOf(modelChain) != modelRef);
            e.err      = modelErr;
            modelRef   = crcOf(sent);
            modelChain = sent;
            expQ.push_back(e);
        end

        idx = 0; gapLeft = 0; firstEn = -1; budget = 0; doneSeen = 0; aborted = 0;
        @(negedge clk);
        start   = 1'b1;
        verify  = vfy;
        startAt = cyc + 1;
        while (1) begin
            if (budget > 0) begin
                if (cfg_en && firstEn < 0) firstEn = cyc;
                if (done) doneSeen = 1;
            end
            if (doneSeen || budget >= 3000) break;
            if (abortAt > 0 && busy && bit_count == 9'(abortAt)) begin
                rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0;
                @(negedge clk);
                checkOutput("abort_cfg_en", BS'(cfg_en), BS'(0));
                checkOutput("abort_busy", BS'(busy), BS'(0));
                checkOutput("abort_bit_count", BS'(bit_count), BS'(0));
                rst_n    = 1'b1;
                modelRef = 8'h00;
                modelErr = 1'b0;
                aborted  = 1;
                break;
            end
            if (poke && busy && bit_count == 9'd50) begin
                start  = 1'b1;
                verify = ~vfy;
            end
            if (mode == 2)          byte_valid = ($urandom_range(0, 3) != 0);
            else if (gapLeft > 0) begin
                byte_valid = 1'b0;
                if (byte_ready) gapLeft--;
            end else                byte_valid = 1'b1;
            byte_data = bytes[(idx < 40) ? idx : 39];
            if (byte_ready && byte_valid) begin
                idx++;
                if (mode == 1 && (idx % 4) == 0) gapLeft = 5;
            end
            @(negedge clk);
            budget++;
            start = 1'b0;
        end

        if (!aborted) begin
            if (!doneSeen) begin
                checks++;
                fails++;
                $display("[TB] FAIL pass_timeout: got no done after %0d cycles, expected done", budget);
            end
            if (poke) start = 1'b1;
            byte_valid = 1'b1;
            checkOutput("bytes_accepted", BS'(idx), BS'(NBYTES));
            if (mode != 2) checkOutput("first_cfg_en_latency", BS'(firstEn - startAt), BS'(2));
            @(negedge clk);
            start = 1'b0; byte_valid = 1'b0;
            if (poke) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput("ignored_start_busy", BS'(busy), BS'(0));
                    checkOutput("ignored_start_cfg_en", BS'(cfg_en), BS'(0));
                end
            end
        end
    endtask

    task automatic flipChainBit(input int k);
        @(negedge clk);
        flipMask    = '0;
        flipMask[k] = 1'b1;
        flipReq     = 1'b1;
        @(negedge clk);
        flipReq    = 1'b0;
        modelChain = modelChain ^ flipMask;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; verify = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cfg_en", BS'(cfg_en), BS'(0));
        checkOutput("reset_cfg_bs", BS'(cfg_bs), BS'(0));
        checkOutput("reset_byte_ready", BS'(byte_ready), BS'(0));
        checkOutput("reset_busy", BS'(busy), BS'(0));
        checkOutput("reset_done", BS'(done), BS'(0));
        checkOutput("reset_readback_err", BS'(readback_err), BS'(0));
        checkOutput("reset_bit_count", BS'(bit_count), BS'(0));
        rst_n = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_wins_idle", BS'(busy), BS'(0));

        applyStimulus(0, 0, 'hA5, 0, 0);
        applyStimulus(0, 1, 'hA5, 0, 0);
        applyStimulus(0, 0, 'h3C, 0, 0);
        applyStimulus(1, 0, 'h3C, 0, 0);
        flipChainBit($urandom_range(0, BS - 1));
        applyStimulus(1, 0, 'h3C, 0, 0);
        applyStimulus(0, 2, -1, 0, 0);
        applyStimulus(0, 0, -1, 0, 1);
        applyStimulus(0, 0, 'h5A, 100, 0);
        applyStimulus(0, 0, -1, 0, 0);
        for (int p = 0; p < 3; p++) applyStimulus(1'($urandom_range(0, 1)), 2, -1, 0, 0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", BS'(expQ.size()), BS'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
